nios2_control_irq_ctrl_0: RTL and testbench
===========================================

// Module: nios2_control_irq_ctrl_0
// PURPOSE
//  Avalon-MM interrupt aggregator downstream of the interval timer and other IRQ sources.
//  - Synchronises up to NUM_IRQ request lines (timer irq on bit 0).
//  - Latches edge events and masks per source.
//  - Drives one irq line to the Nios II, plus a prioritised vector register for the ISR.
// PARAMETERS
//  NUM_IRQ    8      number of irq_in sources, legal range 1..16
//  EDGE_MASK  16'h0  bit i=1: source i is rising-edge latched; 0: level (pending follows input)
// PORTS
//  clk         in   1        system clock
//  reset_n     in   1        asynchronous active-low reset
//  address     in   3        register word select
//  chipselect  in   1        slave select
//  write_n     in   1        active-low write strobe; write when chipselect && ~write_n
//  writedata   in   16       write data
//  readdata    out  16       registered read data
//  irq_in      in   NUM_IRQ  request inputs, any clock phase
//  irq         out  1        interrupt to CPU, active high
// BEHAVIOUR
//  Reset: all registers 0. readdata=0, irq=0, enable=0, gen=0, pending=0, sync stages=0.
//  Input path:
//  - sync1 <= irq_in; sync2 <= sync1; sync3 <= sync2 (sync3 feeds edge detect only).
//  Pending bit i:
//  - Level source: pending[i] <= sync2[i]. W1C and FORCE are ignored.
//  - Edge source, set: sync2 & ~sync3, or FORCE write bit i=1.
//  - Edge source, clear: PENDING write bit i=1.
//  - Edge source, set and clear in the same cycle: set wins; no event is lost.
//  active = pending & enable (bits >= NUM_IRQ read 0).
//  irq = gen && |active. Combinational from registers, no glitch source.
//  Latency: irq_in high sampled at edge n -> pending at edge n+2 -> irq high after edge n+2.
//  Register map (address):
//  - 0 PENDING  R/W1C  [NUM_IRQ-1:0] pending
//  - 1 ENABLE   R/W    per-source mask
//  - 2 ACTIVE   R      pending & enable
//  - 3 VECTOR   R      [15]=|active; [3:0]=lowest-numbered active index, 0 when none
//  - 4 FORCE    W      write-1 sets edge-source pending; reads 0
//  - 5 RAW      R      sync2 (synchronised input levels)
//  - 6 CONTROL  R/W    [0]=gen global enable; other bits read 0
//  - 7 reserved        reads 0, writes ignored
//  Reads:
//  - readdata <= mux(address) on every clk edge (1-cycle latency; no chipselect gating).
//  - Reads have no side effects.
//  Writes:
//  - Take effect at the clk edge where chipselect && ~write_n.
//  - Writes to RO registers are ignored.
//  Bits of writedata above NUM_IRQ-1 are ignored everywhere.
//  Priority: lowest index wins. The timer's bit 0 therefore always has top priority.
//  Clearing enable or gen removes irq the next cycle; pending is retained.
//  Asserting reset_n low mid-operation clears everything immediately, including latched edges.
//  Edge lost while reset is asserted: input already high at reset release is not an edge
//  (sync3 samples it too).
// TESTING
//  1 Reset: hold reset_n=0, irq_in=8'hFF -> irq=0, readdata=0; release, read ACTIVE -> 0.
//  2 Timer path (EDGE_MASK=16'h0001):
//    - ENABLE=1, CONTROL=1, pulse irq_in[0] one cycle at edge n -> irq=1 after edge n+2.
//    - VECTOR reads 16'h8000.
//    - Write PENDING=1 -> irq=0 next cycle.
//  3 Priority: level sources 3 and 5 held high, ENABLE=8'h28, gen=1 -> VECTOR=16'h8003.
//    Drop irq_in[3] -> VECTOR=16'h8005 three cycles later.
//  4 Set/clear collision: edge on bit 0 in the same cycle as W1C of bit 0 -> PENDING stays 1.
//  5 Masking: pending bit 2 (edge) set, ENABLE=0 -> irq=0, PENDING reads 16'h0004.
//    ENABLE=4 -> irq=1 next cycle.
//  6 FORCE: write FORCE=16'hFFFF with EDGE_MASK=16'h0001 -> PENDING=16'h0001 only.
//    Reset mid-pending -> PENDING=0.

Source files
------------

// File: rtl/nios2_control_irq_ctrl_0.sv
// Avalon-MM interrupt aggregator: synchronises request lines, latches edge or level
// pending state, masks per source and exposes a lowest-index-first vector to the ISR.
module nios2_control_irq_ctrl_0 #(
   parameter int          NUM_IRQ   = 8,
   parameter logic [15:0] EDGE_MASK = 16'h0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq
);

   localparam logic [NUM_IRQ-1:0] EDGE_SRC = EDGE_MASK[NUM_IRQ-1:0];

   logic [NUM_IRQ-1:0] sync1, sync2, sync3;
   logic [NUM_IRQ-1:0] pending, enable, active;
   logic [NUM_IRQ-1:0] wr_bits, rise, pend_set, pend_clr, pend_next;
   logic [2:0]         warm;
   logic               gen, wr;
   logic [3:0]         vec_idx;
   logic [15:0]        rd_next;

   assign wr      = chipselect && !write_n;
   assign wr_bits = writedata[NUM_IRQ-1:0];
   assign active  = pending & enable;
   assign irq     = gen && (|active);

   // Edge detection stays disarmed until sync3 holds a real sample, so an input
   // already high when reset is released never counts as a rising edge.
   assign rise     = warm[2] ? (sync2 & ~sync3) : '0;
   assign pend_set = rise | ((wr && address == 3'd4) ? wr_bits : '0);
   assign pend_clr = (wr && address == 3'd0) ? wr_bits : '0;
   assign pend_next = (EDGE_SRC & (pend_set | (pending & ~pend_clr)))
                    | (~EDGE_SRC & sync2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1   <= '0;
         sync2   <= '0;
         sync3   <= '0;
         warm    <= '0;
         pending <= '0;
         enable  <= '0;
         gen     <= 1'b0;
      end else begin
         sync1   <= irq_in;
         sync2   <= sync1;
         sync3   <= sync2;
         warm    <= {warm[1:0], 1'b1};
         pending <= pend_next;
         if (wr && address == 3'd1)
            enable <= wr_bits;
         if (wr && address == 3'd6)
            gen <= writedata[0];
      end
   end

   // Scan downward so the lowest-numbered active source is the one left standing.
   always_comb begin
      vec_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i])
            vec_idx = 4'(i);
      end
   end

   always_comb begin
      rd_next = '0;
      case (address)
         3'd0:    rd_next = 16'(pending);
         3'd1:    rd_next = 16'(enable);
         3'd2:    rd_next = 16'(active);
         3'd3:    rd_next = {|active, 11'b0, vec_idx};
         3'd5:    rd_next = 16'(sync2);
         3'd6:    rd_next = {15'b0, gen};
         default: rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         readdata <= '0;
      else
         readdata <= rd_next;
   end

endmodule

// File: tb/tb_nios2_control_irq_ctrl_0.sv
// Self-checking bench for nios2_control_irq_ctrl_0: directed scenarios plus random
// traffic compared every cycle against a behavioural model of the register block.
module tb_nios2_control_irq_ctrl_0;

   localparam int         NUM_IRQ   = 8;
   localparam logic [7:0] EDGE_BITS = 8'h05;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = '0;
   logic [15:0] readdata;
   logic [7:0]  irq_in = '0;
   logic        irq;

   int check_cnt = 0;
   int pass_cnt  = 0;

   // Model state: input age history (hist1 = input two edges old), register contents.
   logic [7:0]  hist0 = '0, hist1 = '0, hist2 = '0;
   logic [7:0]  m_pending = '0, m_enable = '0;
   logic        m_gen = 1'b0;
   logic [15:0] m_rd = '0;
   int          m_cnt = 0;

   nios2_control_irq_ctrl_0 #(.NUM_IRQ(NUM_IRQ), .EDGE_MASK(16'h0005)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .irq_in(irq_in), .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] reg_value(input logic [2:0] a);
      logic [7:0] act;
      logic [15:0] v;
      act = m_pending & m_enable;
      v = '0;
      case (a)
         3'd0: v = {8'h0, m_pending};
         3'd1: v = {8'h0, m_enable};
         3'd2: v = {8'h0, act};
         3'd3: begin
            if (act != 0) begin
               v[15] = 1'b1;
               for (int i = 7; i >= 0; i--)
                  if (act[i]) v[3:0] = 4'(i);
            end
         end
         3'd5: v = {8'h0, hist1};
         3'd6: v = {15'h0, m_gen};
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] next_pending();
      logic [7:0] p;
      logic wr;
      wr = chipselect && !write_n;
      p = m_pending;
      for (int i = 0; i < 8; i++) begin
         if (EDGE_BITS[i]) begin
            if ((hist1[i] && !hist2[i] && m_cnt >= 3) || (wr && address == 3'd4 && writedata[i]))
               p[i] = 1'b1;
            else if (wr && address == 3'd0 && writedata[i])
               p[i] = 1'b0;
         end else begin
            p[i] = hist1[i];
         end
      end
      return p;
   endfunction

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         hist0 = '0; hist1 = '0; hist2 = '0;
         m_pending = '0; m_enable = '0; m_gen = 1'b0; m_rd = '0; m_cnt = 0;
      end else begin
         m_rd = reg_value(address);
         m_pending = next_pending();
         if (chipselect && !write_n && address == 3'd1) m_enable = writedata[7:0];
         if (chipselect && !write_n && address == 3'd6) m_gen = writedata[0];
         hist2 = hist1; hist1 = hist0; hist0 = irq_in;
         if (m_cnt < 3) m_cnt = m_cnt + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      check_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
   endtask

   task automatic cycleCompare();
      forever begin
         @(negedge clk);
         checkOutput("model_readdata", readdata, m_rd);
         checkOutput("model_irq", {15'h0, irq}, {15'h0, m_gen && ((m_pending & m_enable) != 0)});
      end
   endtask

   task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] a, input logic [15:0] wd);
      @(negedge clk);
      chipselect = cs;
      write_n    = wn;
      address    = a;
      writedata  = wd;
   endtask

   task automatic writeReg(input logic [2:0] a, input logic [15:0] wd);
      applyStimulus(1'b1, 1'b0, a, wd);
      applyStimulus(1'b0, 1'b1, a, 16'h0);
   endtask

   task automatic readReg(input logic [2:0] a, output logic [15:0] d);
      applyStimulus(1'b1, 1'b1, a, 16'h0);
      @(negedge clk);
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [15:0] rd;

   initial begin
      fork
         cycleCompare();
      join_none

      // Reset held with every request line high
      irq_in = 8'hFF;
      idle(3);
      checkOutput("reset_irq", {15'h0, irq}, 16'h0);
      checkOutput("reset_readdata", readdata, 16'h0);
      reset_n = 1'b1;
      idle(2);
      irq_in = 8'h00;
      readReg(3'd2, rd);
      checkOutput("reset_active", rd, 16'h0);
      idle(3);

      // Timer edge path on bit 0
      writeReg(3'd1, 16'h0001);
      writeReg(3'd6, 16'h0001);
      irq_in[0] = 1'b1;
      @(negedge clk);
      irq_in[0] = 1'b0;
      @(negedge clk);
      checkOutput("timer_irq_early", {15'h0, irq}, 16'h0);
      @(negedge clk);
      checkOutput("timer_irq_set", {15'h0, irq}, 16'h1);
      readReg(3'd3, rd);
      checkOutput("timer_vector", rd, 16'h8000);
      writeReg(3'd0, 16'h0001);
      checkOutput("timer_w1c_irq", {15'h0, irq}, 16'h0);

      // Priority among level sources 3 and 5
      irq_in = 8'h28;
      writeReg(3'd1, 16'h0028);
      idle(3);
      readReg(3'd3, rd);
      checkOutput("prio_vec3", rd, 16'h8003);
      irq_in = 8'h20;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checkOutput("prio_vec_hold", readdata, 16'h8003);
      @(negedge clk);
      checkOutput("prio_vec5", readdata, 16'h8005);
      irq_in = 8'h00;
      writeReg(3'd1, 16'h0000);
      idle(3);

      // Edge set colliding with a W1C of the same bit
      writeReg(3'd0, 16'hFFFF);
      writeReg(3'd4, 16'h0001);
      irq_in[0] = 1'b1;
      @(negedge clk);
      irq_in[0] = 1'b0;
      applyStimulus(1'b1, 1'b0, 3'd0, 16'h0001);
      applyStimulus(1'b0, 1'b1, 3'd0, 16'h0000);
      readReg(3'd0, rd);
      checkOutput("collision_pending", rd, 16'h0001);

      // Masking of an edge source
      writeReg(3'd0, 16'hFFFF);
      irq_in[2] = 1'b1;
      @(negedge clk);
      irq_in[2] = 1'b0;
      idle(2);
      checkOutput("mask_irq_off", {15'h0, irq}, 16'h0);
      readReg(3'd0, rd);
      checkOutput("mask_pending", rd, 16'h0004);
      writeReg(3'd1, 16'h0004);
      checkOutput("mask_irq_on", {15'h0, irq}, 16'h1);

      // FORCE only reaches edge sources; reset wipes latched state
      writeReg(3'd1, 16'h0000);
      writeReg(3'd0, 16'hFFFF);
      writeReg(3'd4, 16'hFFFF);
      readReg(3'd0, rd);
      checkOutput("force_pending", rd, 16'h0005);
      address = 3'd0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 checkOutput("midreset_readdata", readdata, 16'h0);
      idle(2);
      reset_n = 1'b1;
      readReg(3'd0, rd);
      checkOutput("midreset_pending", rd, 16'h0);

      // Random traffic checked by the per-cycle compare
      writeReg(3'd6, 16'h0001);
      for (int c = 0; c < 3000; c++) begin
         applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                       3'($urandom_range(0, 7)), 16'($urandom));
         if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
         if (c == 1500) begin
            #2 reset_n = 1'b0;
            idle(2);
            reset_n = 1'b1;
         end
      end
      applyStimulus(1'b0, 1'b1, 3'd0, 16'h0);
      idle(2);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
